// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : md_sequencer
//  Description : Multi-cycle MULT/DIV sequencer owning the architectural
//                HI/LO registers. Fixed parameterised latencies, registered
//                busy, handler-driven stop (abort) and restore (undo HI/LO).
//                Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU)
//                are built only when the macro MD_MADD_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_stop,
    input  logic        md_restore,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd7;
    localparam logic [3:0] c_OP_MADDU = 4'd8;
    localparam logic [3:0] c_OP_MSUB  = 4'd9;
    localparam logic [3:0] c_OP_MSUBU = 4'd10;
`endif

    localparam logic [3:0] c_MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] c_DIV_LOAD  = 4'(DIV_CYCLES - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [31:0] r_p_hi;
    logic [31:0] r_p_lo;
    logic        r_p_valid;
    logic [31:0] r_u_hi;
    logic [31:0] r_u_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Arithmetic datapath wires
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_signed;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [31:0] w_quo_mag;
    logic [31:0] w_rem_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
`ifdef MD_MADD_EN
    logic [63:0] w_acc_base;
`endif

    // Request decode
    logic        w_start;
    logic [3:0]  w_load;
    logic [63:0] w_res;
    logic        w_res_ok;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_accept;

    // Both products take the low 64 bits of a 64x64 multiply; sign extension
    // of the operands makes the low half equal to the signed product.
    always_comb begin
        w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        w_prod_u = {32'd0, a} * {32'd0, b};
    end

    // One shared unsigned divider; signed division runs on magnitudes and
    // fixes signs afterwards (quotient sign = xor, remainder = dividend sign).
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, rem 0.
    always_comb begin
        w_div_signed = (op == c_OP_DIV);
        w_dvd_mag    = (w_div_signed && a[31]) ? (32'd0 - a) : a;
        w_dvs_mag    = (w_div_signed && b[31]) ? (32'd0 - b) : b;
        w_quo_mag    = (w_dvs_mag != 32'd0) ? (w_dvd_mag / w_dvs_mag) : 32'd0;
        w_rem_mag    = (w_dvs_mag != 32'd0) ? (w_dvd_mag % w_dvs_mag) : 32'd0;
        w_quo        = (w_div_signed && (a[31] ^ b[31])) ? (32'd0 - w_quo_mag) : w_quo_mag;
        w_rem        = (w_div_signed && a[31]) ? (32'd0 - w_rem_mag) : w_rem_mag;
    end

`ifdef MD_MADD_EN
    // Accumulator base is the architectural HI/LO seen at the request edge
    always_comb begin
        w_acc_base = {r_hi, r_lo};
    end
`endif

    // Decode the E-stage request into start / result / move controls
    always_comb begin
        w_start  = 1'b0;
        w_load   = 4'd0;
        w_res    = 64'd0;
        w_res_ok = 1'b0;
        w_mthi   = 1'b0;
        w_mtlo   = 1'b0;
        case (op)
            c_OP_MULT: begin
                w_start  = 1'b1;
                w_load   = c_MULT_LOAD;
                w_res    = w_prod_s;
                w_res_ok = 1'b1;
            end
            c_OP_MULTU: begin
                w_start  = 1'b1;
                w_load   = c_MULT_LOAD;
                w_res    = w_prod_u;
                w_res_ok = 1'b1;
            end
            c_OP_DIV, c_OP_DIVU: begin
                // Divide by zero still spends the latency but never commits
                w_start  = 1'b1;
                w_load   = c_DIV_LOAD;
                w_res    = {w_rem, w_quo};
                w_res_ok = (b != 32'd0);
            end
            c_OP_MTHI: w_mthi = 1'b1;
            c_OP_MTLO: w_mtlo = 1'b1;
`ifdef MD_MADD_EN
            c_OP_MADD: begin
                w_start  = 1'b1;
                w_load   = c_MULT_LOAD;
                w_res    = w_acc_base + w_prod_s;
                w_res_ok = 1'b1;
            end
            c_OP_MADDU: begin
                w_start  = 1'b1;
                w_load   = c_MULT_LOAD;
                w_res    = w_acc_base + w_prod_u;
                w_res_ok = 1'b1;
            end
            c_OP_MSUB: begin
                w_start  = 1'b1;
                w_load   = c_MULT_LOAD;
                w_res    = w_acc_base - w_prod_s;
                w_res_ok = 1'b1;
            end
            c_OP_MSUBU: begin
                w_start  = 1'b1;
                w_load   = c_MULT_LOAD;
                w_res    = w_acc_base - w_prod_u;
                w_res_ok = 1'b1;
            end
`endif
            default: ;
        endcase
        w_accept = (r_state == c_ST_IDLE) && !md_stop;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: stop aborts RUN, counter expiry returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept && w_start) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (md_stop || (r_cnt == 4'd0)) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outputs: busy follows the registered state, HI/LO are registers
    always_comb begin
        busy = (r_state == c_ST_RUN);
        hi   = r_hi;
        lo   = r_lo;
    end

    // Counter, pending result, undo snapshot and HI/LO updates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 4'd0;
            r_p_hi    <= 32'd0;
            r_p_lo    <= 32'd0;
            r_p_valid <= 1'b0;
            r_u_hi    <= 32'd0;
            r_u_lo    <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            if (w_accept) begin
                if (w_start) begin
                    r_cnt     <= w_load;
                    r_p_hi    <= w_res[63:32];
                    r_p_lo    <= w_res[31:0];
                    r_p_valid <= w_res_ok;
                end
                if (w_mthi) begin
                    r_u_hi <= r_hi;
                    r_u_lo <= r_lo;
                    r_hi   <= a;
                end
                if (w_mtlo) begin
                    r_u_hi <= r_hi;
                    r_u_lo <= r_lo;
                    r_lo   <= a;
                end
            end else if (r_state == c_ST_RUN) begin
                if (md_stop) begin
                    r_cnt     <= 4'd0;
                    r_p_valid <= 1'b0;
                end else if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    if (r_p_valid) begin
                        r_hi <= r_p_hi;
                        r_lo <= r_p_lo;
                    end
                    r_p_valid <= 1'b0;
                end
            end
            // Restore is written last so it overrides a same-cycle commit
            if (md_restore) begin
                r_hi <= r_u_hi;
                r_lo <= r_u_lo;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_sequencer
//  Description : Directed self-checking bench for md_sequencer. Define
//                MD_MADD_EN for both bench and design to cover accumulate ops.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_md_sequencer;

    localparam logic [3:0] c_NONE  = 4'd0;
    localparam logic [3:0] c_MULT  = 4'd1;
    localparam logic [3:0] c_MULTU = 4'd2;
    localparam logic [3:0] c_DIV   = 4'd3;
    localparam logic [3:0] c_DIVU  = 4'd4;
    localparam logic [3:0] c_MTHI  = 4'd5;
    localparam logic [3:0] c_MTLO  = 4'd6;
    localparam logic [3:0] c_MADD  = 4'd7;
    localparam logic [3:0] c_MSUBU = 4'd10;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_stop;
    logic        md_restore;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;
    int n_busy;

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .a          (a),
        .b          (b),
        .md_stop    (md_stop),
        .md_restore (md_restore),
        .busy       (busy),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; observe 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a request for one edge, then count busy cycles (bounded)
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int n);
        op = o; a = x; b = y;
        step();
        op = c_NONE;
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        op = c_NONE; a = 32'd0; b = 32'd0; md_stop = 1'b0; md_restore = 1'b0;
        do_reset();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        // MULT -2 * 3
        run_op(c_MULT, 32'hFFFF_FFFE, 32'd3, n_busy);
        chk("mult_cycles", n_busy, 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU issued back-to-back in the first non-busy cycle
        run_op(c_MULTU, 32'hFFFF_FFFE, 32'd3, n_busy);
        chk("multu_cycles", n_busy, 32'd5);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        // DIV -7 / 2
        run_op(c_DIV, 32'hFFFF_FFF9, 32'd2, n_busy);
        chk("div_cycles", n_busy, 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU by zero: latency spent, HI/LO untouched
        run_op(c_DIVU, 32'd7, 32'd0, n_busy);
        chk("divz_cycles", n_busy, 32'd10);
        chk("divz_lo", lo, 32'hFFFF_FFFD);
        chk("divz_hi", hi, 32'hFFFF_FFFF);

        // Signed overflow case
        run_op(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n_busy);
        chk("divov_lo", lo, 32'h8000_0000);
        chk("divov_hi", hi, 32'h0000_0000);

        // DIVU large unsigned operands
        run_op(c_DIVU, 32'hFFFF_FFF9, 32'd2, n_busy);
        chk("divu_lo", lo, 32'h7FFF_FFFC);
        chk("divu_hi", hi, 32'h0000_0001);

        // Stop in busy cycle 3 aborts MULT 6*7
        do_reset();
        op = c_MULT; a = 32'd6; b = 32'd7;
        step();
        op = c_NONE;
        step();
        step();
        md_stop = 1'b1;
        step();
        md_stop = 1'b0;
        chk("stop_busy", {31'd0, busy}, 32'd0);
        chk("stop_hi", hi, 32'd0);
        chk("stop_lo", lo, 32'd0);
        repeat (8) step();
        chk("stop_nocommit_lo", lo, 32'd0);
        run_op(c_MULT, 32'd2, 32'd3, n_busy);
        chk("after_stop_lo", lo, 32'd6);
        chk("after_stop_hi", hi, 32'd0);

        // Stop while idle suppresses a start
        op = c_MULT; a = 32'd5; b = 32'd5; md_stop = 1'b1;
        step();
        op = c_NONE; md_stop = 1'b0;
        chk("idle_stop_busy", {31'd0, busy}, 32'd0);
        repeat (6) step();
        chk("idle_stop_lo", lo, 32'd6);

        // MTLO, MTHI, then restore to the pre-MTHI snapshot
        op = c_MTLO; a = 32'h11;
        step();
        chk("mtlo_lo", lo, 32'h11);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        op = c_MTHI; a = 32'h55;
        step();
        op = c_NONE;
        chk("mthi_hi", hi, 32'h55);
        md_restore = 1'b1;
        step();
        md_restore = 1'b0;
        chk("restore_hi", hi, 32'd0);
        chk("restore_lo", lo, 32'h11);

        // Reset in busy cycle 2 of a DIV
        op = c_DIV; a = 32'd100; b = 32'd7;
        step();
        op = c_NONE;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        repeat (12) step();
        chk("rstmid_nocommit_lo", lo, 32'd0);

`ifdef MD_MADD_EN
        op = c_MTLO; a = 32'd10;
        step();
        op = c_NONE;
        run_op(c_MADD, 32'd3, 32'd4, n_busy);
        chk("madd_cycles", n_busy, 32'd5);
        chk("madd_lo", lo, 32'd22);
        chk("madd_hi", hi, 32'd0);
        run_op(c_MSUBU, 32'd1, 32'd23, n_busy);
        chk("msubu_hi", hi, 32'hFFFF_FFFF);
        chk("msubu_lo", lo, 32'hFFFF_FFFF);
`else
        op = c_MTLO; a = 32'd10;
        step();
        op = c_MADD; a = 32'd3; b = 32'd4;
        step();
        op = c_NONE;
        chk("nomadd_busy", {31'd0, busy}, 32'd0);
        repeat (6) step();
        chk("nomadd_lo", lo, 32'd10);
        chk("nomadd_hi", hi, 32'd0);
        op = c_MSUBU; a = 32'd1; b = 32'd23;
        step();
        op = c_NONE;
        chk("nomsubu_busy", {31'd0, busy}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
